// File: rtl/fetch_pkg.sv
// Shared types and address-field helpers for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StLookup,
        StReq,
        StRefill
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;

    function automatic int unsigned off_w(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned lines,
                                          input int unsigned words_per_line);
        return addr_w - $clog2(lines) - $clog2(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data storage.
// Reads are combinational; one word written per cycle, plus a tag install port.
module icache_array
    import fetch_pkg::*;
#(
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TAG_W          = 26,
    parameter int unsigned IDX_W          = idx_w(LINES),
    parameter int unsigned OFF_W          = off_w(WORDS_PER_LINE)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [OFF_W-1:0]  rd_off_i,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [OFF_W-1:0]  wr_off_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              inst_en_i,
    input  logic [IDX_W-1:0]  inst_idx_i,
    input  logic [TAG_W-1:0]  inst_tag_i,
    input  logic              inst_valid_i,
    input  logic              clear_all_i
);

    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS_PER_LINE];
    logic [LINES-1:0]  valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (clear_all_i) begin
            valid_q <= '0;
        end else if (inst_en_i) begin
            valid_q[inst_idx_i] <= inst_valid_i;
        end
    end

    // Tag and data need no reset: valid gates every use.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_off_i] <= wr_data_i;
        end
        if (inst_en_i) begin
            tag_q[inst_idx_i] <= inst_tag_i;
        end
    end

    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/fetch_stage_icache.sv
// Fetch stage: PC register, direct-mapped I-cache lookup and a multi-beat refill engine.
// A redirect never cancels a refill; flush marks an in-flight line for discard.
module fetch_stage_icache
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       LINES          = 16,
    parameter int unsigned       WORDS_PER_LINE = 4,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pc_src_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              stall_i,
    input  logic              flush_icache_i,
    output logic [DATA_W-1:0] instruction_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              hit_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_resp_data_i,
    output logic [31:0]       hit_count_o,
    output logic [31:0]       miss_count_o
);

    localparam int unsigned OFF_W    = off_w(WORDS_PER_LINE);
    localparam int unsigned IDX_W    = idx_w(LINES);
    localparam int unsigned TAG_W    = tag_w(ADDR_W, LINES, WORDS_PER_LINE);
    localparam int unsigned LINE_LSB = OFF_W + 2;
    localparam int unsigned TAG_LSB  = LINE_LSB + IDX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic              discard_q, discard_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              hit;
    logic              start_miss;
    logic              beat_valid;
    logic              last_beat;

    logic unused_bt;
    assign unused_bt = ^branch_target_i[1:0];

    icache_array #(
        .LINES         (LINES),
        .WORDS_PER_LINE(WORDS_PER_LINE),
        .DATA_W        (DATA_W),
        .TAG_W         (TAG_W),
        .IDX_W         (IDX_W),
        .OFF_W         (OFF_W)
    ) u_array (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (pc_q[TAG_LSB-1:LINE_LSB]),
        .rd_off_i    (pc_q[LINE_LSB-1:2]),
        .rd_tag_o    (rd_tag),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data),
        .wr_en_i     (beat_valid),
        .wr_idx_i    (miss_addr_q[TAG_LSB-1:LINE_LSB]),
        .wr_off_i    (beat_q),
        .wr_data_i   (mem_resp_data_i),
        .inst_en_i   (last_beat),
        .inst_idx_i  (miss_addr_q[TAG_LSB-1:LINE_LSB]),
        .inst_tag_i  (miss_addr_q[ADDR_W-1:TAG_LSB]),
        .inst_valid_i(!discard_q && !flush_icache_i),
        .clear_all_i (flush_icache_i)
    );

    assign hit        = (state_q == StLookup) && rd_valid && (rd_tag == pc_q[ADDR_W-1:TAG_LSB]);
    assign start_miss = (state_q == StLookup) && !hit && !pc_src_i && !flush_icache_i;
    assign beat_valid = (state_q == StRefill) && mem_resp_valid_i;
    assign last_beat  = beat_valid && (beat_q == LAST_BEAT);

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StLookup;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLookup: if (start_miss)      state_d = StReq;
            StReq:    if (mem_req_ready_i) state_d = StRefill;
            StRefill: if (last_beat)       state_d = StLookup;
            default:                       state_d = StLookup;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem_req_valid_o = (state_q == StReq);
    end

    always_comb begin
        pc_d        = pc_q;
        miss_addr_d = miss_addr_q;
        beat_d      = beat_q;
        discard_d   = discard_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        if (pc_src_i) begin
            pc_d = {branch_target_i[ADDR_W-1:2], 2'b00};
        end else if (hit && !stall_i) begin
            pc_d = pc_q + ADDR_W'(INSTR_BYTES);
        end

        if (start_miss) begin
            miss_addr_d = {pc_q[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
        end

        if (hit && !stall_i && hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end

        if (state_q == StReq && mem_req_ready_i) begin
            beat_d = '0;
        end else if (beat_valid) begin
            beat_d = beat_q + OFF_W'(1);
        end

        if (state_q != StLookup && flush_icache_i) discard_d = 1'b1;
        // The in-flight line is finished either way, so its discard mark goes with it.
        if (last_beat) discard_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= RESET_PC;
            miss_addr_q <= '0;
            beat_q      <= '0;
            discard_q   <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            miss_addr_q <= miss_addr_d;
            beat_q      <= beat_d;
            discard_q   <= discard_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign instruction_o  = rd_data;
    assign pc_o           = pc_q;
    assign hit_o          = hit;
    assign mem_req_addr_o = miss_addr_q;
    assign hit_count_o    = hit_cnt_q;
    assign miss_count_o   = miss_cnt_q;

endmodule

// File: doc/fetch_stage_icache.md
Name: fetch_stage_icache

Overview:
- Parameterised instruction-fetch stage: PC register, direct-mapped instruction cache, and a refill engine on a valid/ready memory port.
- Next generation of the single-cycle fetch block. Adds configurable cache geometry, downstream stall, miss handling with multi-beat refill, whole-cache invalidate and hit/miss counters.
- Sits between the branch-resolution logic, which supplies pc_src and branch_target, and the decode stage.

Parameters:
- ADDR_W, 32, PC and memory address width.
- DATA_W, 32, instruction width; fixed at 32, byte-addressed, 4-byte instructions.
- LINES, 16, cache lines; power of 2, at least 2.
- WORDS_PER_LINE, 4, words per line; power of 2, at least 2. Also the refill beat count.
- RESET_PC, 32'h00000000, PC value after reset.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- pc_src, in, 1, redirect request: take branch_target.
- branch_target, in, ADDR_W, redirect address; bits [1:0] are ignored and treated as 0.
- stall, in, 1, decode cannot accept; hold PC.
- flush_icache, in, 1, invalidate all lines.
- instruction, out, DATA_W, fetched word; valid only when hit=1.
- pc, out, ADDR_W, address of instruction.
- hit, out, 1, instruction/pc valid this cycle.
- mem_req_valid, out, 1, refill request.
- mem_req_ready, in, 1, memory accepts the request.
- mem_req_addr, out, ADDR_W, line-aligned refill address.
- mem_resp_valid, in, 1, one refill beat present.
- mem_resp_data, in, DATA_W, refill beat data, in ascending word order.
- hit_count, out, 32, saturating count of hit cycles.
- miss_count, out, 32, saturating count of misses.

Behaviour:
- Address split: off = log2(WORDS_PER_LINE) bits above bit 1; idx = log2(LINES) bits above off; tag = remaining upper bits.
- Reset (synchronous, rst=1 at a clk edge):
  - pc=RESET_PC, all valid bits 0, state=LOOKUP.
  - hit=0, mem_req_valid=0, mem_req_addr=0, both counters 0, discard flag 0.
  - Reset mid-refill abandons the refill. The memory side must tolerate this; no line is installed.
- Lookup is combinational on pc. hit = (state==LOOKUP) & valid[idx] & (tag_array[idx]==tag). instruction = data_array[idx][off].
- PC update, priority order:
  - rst.
  - pc_src=1: pc <= {branch_target[ADDR_W-1:2],2'b00}. Applies in any state, overrides stall.
  - state==LOOKUP & hit & !stall: pc <= pc+4. Wraps modulo 2^ADDR_W.
  - otherwise hold.
- FSM states: LOOKUP, REQ, REFILL.
  - LOOKUP: on a miss (!hit) with pc_src=0 and flush_icache=0: latch miss line address {pc[ADDR_W-1:off+2],0}, increment miss_count, go to REQ. A miss with pc_src=1 is not counted and not requested; the new PC is looked up next cycle.
  - REQ: mem_req_valid=1, mem_req_addr = latched address. When mem_req_ready=1: go to REFILL, beat counter = 0.
  - REFILL: each mem_resp_valid=1 cycle writes data_array[line_idx][beat] and increments beat. On the last beat (beat==WORDS_PER_LINE-1 with mem_resp_valid=1): write the tag; set the valid bit unless discard=1; clear discard; go to LOOKUP. A hit is possible the following cycle.
- Redirect during REQ or REFILL: the PC updates immediately. The outstanding refill completes and installs its line, because memory cannot be cancelled. Lookup of the new PC follows.
- flush_icache:
  - Clears all valid bits in one cycle.
  - In REQ or REFILL it also sets discard, so the in-flight line is not marked valid.
  - In LOOKUP, flush takes precedence over starting a miss. That cycle's hit still reports, since valid bits clear at the edge.
- Stall while hit: hit stays 1 and instruction/pc are held stable. Stall has no effect on an in-progress refill.
- hit_count increments on every cycle with hit & !stall. Both counters saturate at 32'hFFFFFFFF.
- Latency:
  - Hit: 0 cycles (same-cycle output).
  - Miss: 1 cycle to REQ, plus request-handshake wait, plus WORDS_PER_LINE response beats, plus 1 cycle back to LOOKUP.

Decomposition:
- Package fetch_pkg holds:
  - state enum (LOOKUP, REQ, REFILL);
  - address-field width functions (IDX_W, OFF_W, TAG_W from the parameters);
  - INSTR_BYTES=4.
- One sub-module, icache_array. It holds tag/valid/data storage with combinational read, a single word-write port, a tag-install port and a clear-all-valid input.
- FSM, PC and counters stay in fetch_stage_icache.

Test Plan:
- Cold start, defaults, memory ready=1, one beat per cycle, data = address: hit=0, then miss_count=1 and mem_req_addr=0. After 4 beats, hit=1 with pc=0, instruction=0. Then pc=4, 8, 12 hit on consecutive cycles; pc=16 misses and gives mem_req_addr=16.
- Stall held 3 cycles at pc=8 with hit: pc and instruction stay fixed and hit_count does not increment. Release gives pc=12 next cycle.
- pc_src=1, branch_target=32'h00000103, with stall=1: pc becomes 32'h00000100 the next cycle (stall overridden). A miss is then issued for line 32'h00000100.
- Redirect to 32'h40 during beat 2 of the refill of line 0: the line-0 refill completes and installs, then the miss at 0x40 requests 32'h00000040. A later jump to 0 hits without a request.
- flush_icache during REFILL of line 0x20: after completion, 0x20 still misses (discard honoured) and every previously valid line misses.
- Alias test, LINES=16, line 64 B: fill 0x000, then fetch 0x400. This misses and evicts; returning to 0x000 misses again, giving miss_count=3. rst asserted mid-REQ returns pc=RESET_PC, counters 0, all lines invalid.
